// File: rtl/perf_monitor_if.sv
// rtl/perf_monitor_if.sv - CPU event/control inputs and count/BCD outputs of perf_monitor
interface perf_monitor_if #(
    parameter int NUM_CHANNELS     = 4,
    parameter int COUNT_WIDTH      = 32,
    parameter int PC_WIDTH         = 12,
    parameter int NUMBER_OF_DIGITS = 8
);
    localparam int SEL_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic                          cpu_tick;
    logic [PC_WIDTH-1:0]           pc;
    logic [NUM_CHANNELS-1:0]       events;
    logic [SEL_W-1:0]              sel;
    logic                          clear;
    logic                          halted;
    logic [COUNT_WIDTH-1:0]        count_out;
    logic [NUM_CHANNELS-1:0]       saturated;
    logic [4*NUMBER_OF_DIGITS-1:0] bcd_digits;
    logic                          bcd_valid;
    logic                          dec_ovf;

    modport master (
        output cpu_tick, pc, events, sel, clear,
        input  halted, count_out, saturated, bcd_digits, bcd_valid, dec_ovf
    );

    modport slave (
        input  cpu_tick, pc, events, sel, clear,
        output halted, count_out, saturated, bcd_digits, bcd_valid, dec_ovf
    );
endinterface

// File: rtl/perf_monitor.sv
// rtl/perf_monitor.sv - saturating per-channel event counters, halt on FINAL_PC,
// and a free-running double-dabble converter for the selected channel
module perf_monitor #(
    parameter int NUM_CHANNELS     = 4,
    parameter int COUNT_WIDTH      = 32,
    parameter int PC_WIDTH         = 12,
    parameter int FINAL_PC         = 4095,
    parameter int NUMBER_OF_DIGITS = 8
) (
    input logic           CLK_50,
    input logic           resetN,
    perf_monitor_if.slave mon
);
    localparam int ACC_W = 4 * (NUMBER_OF_DIGITS + 1);
    localparam int BCD_W = 4 * NUMBER_OF_DIGITS;
    localparam int BIT_W = $clog2(COUNT_WIDTH + 1);

    typedef enum logic {CTL_RUN, CTL_HALTED} ctl_e;
    typedef enum logic [1:0] {CV_IDLE, CV_SHIFT, CV_DONE} cv_e;

    ctl_e                    ctl_q, ctl_d;
    logic [COUNT_WIDTH-1:0]  cnt_q [NUM_CHANNELS];
    logic [COUNT_WIDTH-1:0]  cnt_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] sat_q, sat_d;
    logic [COUNT_WIDTH-1:0]  sel_val;

    cv_e                     cv_q, cv_d;
    logic [COUNT_WIDTH-1:0]  shift_q, shift_d;
    logic [ACC_W-1:0]        acc_q, acc_d, acc_adj;
    logic                    carry_q, carry_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic                    valid_q, valid_d;
    logic                    ovf_q, ovf_d;

    // Out-of-range selects fall through to zero
    always_comb begin
        sel_val = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (32'(mon.sel) == 32'(i)) sel_val = cnt_q[i];
        end
    end

    always_comb begin
        ctl_d = ctl_q;
        sat_d = sat_q;
        for (int i = 0; i < NUM_CHANNELS; i++) cnt_d[i] = cnt_q[i];
        if (mon.clear) begin
            ctl_d = CTL_RUN;
            sat_d = '0;
            for (int i = 0; i < NUM_CHANNELS; i++) cnt_d[i] = '0;
        end else if (ctl_q == CTL_RUN && mon.cpu_tick) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (mon.events[i]) begin
                    if (&cnt_q[i]) sat_d[i] = 1'b1;
                    else           cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
                end
            end
            if (mon.pc == PC_WIDTH'(FINAL_PC)) ctl_d = CTL_HALTED;
        end
    end

    always_comb begin
        cv_d    = cv_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        bit_d   = bit_q;
        bcd_d   = bcd_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        acc_adj = acc_q;
        for (int n = 0; n < NUMBER_OF_DIGITS + 1; n++) begin
            if (acc_q[4*n +: 4] >= 4'd5) acc_adj[4*n +: 4] = acc_q[4*n +: 4] + 4'd3;
        end
        unique case (cv_q)
            CV_IDLE: begin
                shift_d = sel_val;
                acc_d   = '0;
                carry_d = 1'b0;
                bit_d   = '0;
                cv_d    = CV_SHIFT;
            end
            CV_SHIFT: begin
                // A bit leaving the top nibble means the value cannot fit in the accumulator
                acc_d   = {acc_adj[ACC_W-2:0], shift_q[COUNT_WIDTH-1]};
                carry_d = carry_q | acc_adj[ACC_W-1];
                shift_d = shift_q << 1;
                bit_d   = bit_q + BIT_W'(1);
                if (bit_q == BIT_W'(COUNT_WIDTH - 1)) cv_d = CV_DONE;
            end
            CV_DONE: begin
                valid_d = 1'b1;
                if (carry_q || acc_q[ACC_W-1 -: 4] != 4'd0) begin
                    bcd_d = {NUMBER_OF_DIGITS{4'h9}};
                    ovf_d = 1'b1;
                end else begin
                    bcd_d = acc_q[BCD_W-1:0];
                    ovf_d = 1'b0;
                end
                cv_d = CV_IDLE;
            end
            default: cv_d = CV_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50) begin
        if (!resetN) begin
            ctl_q   <= CTL_RUN;
            sat_q   <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) cnt_q[i] <= '0;
            cv_q    <= CV_IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            bit_q   <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ctl_q   <= ctl_d;
            sat_q   <= sat_d;
            for (int i = 0; i < NUM_CHANNELS; i++) cnt_q[i] <= cnt_d[i];
            cv_q    <= cv_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            bit_q   <= bit_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign mon.halted     = (ctl_q == CTL_HALTED);
    assign mon.count_out  = sel_val;
    assign mon.saturated  = sat_q;
    assign mon.bcd_digits = bcd_q;
    assign mon.bcd_valid  = valid_q;
    assign mon.dec_ovf    = ovf_q;
endmodule

// File: tb/tb_perf_monitor.sv
// tb/tb_perf_monitor.sv - perf_monitor bench: directed and random steps checked against a behavioural model
module tb_perf_monitor;
    logic clk = 1'b0;
    always #10 clk = ~clk;

    perf_monitor_if #(.NUM_CHANNELS(4), .COUNT_WIDTH(32), .PC_WIDTH(12), .NUMBER_OF_DIGITS(8)) if0 ();
    perf_monitor_if #(.NUM_CHANNELS(3), .COUNT_WIDTH(8), .PC_WIDTH(8), .NUMBER_OF_DIGITS(2)) if1 ();

    logic        rst_r  [2];
    logic        tick_r [2];
    logic [11:0] pc_r   [2];
    logic [3:0]  ev_r   [2];
    logic [1:0]  sel_r  [2];
    logic        clr_r  [2];

    perf_monitor #(.NUM_CHANNELS(4), .COUNT_WIDTH(32), .PC_WIDTH(12), .FINAL_PC(4095),
                   .NUMBER_OF_DIGITS(8)) dut0 (.CLK_50(clk), .resetN(rst_r[0]), .mon(if0));
    perf_monitor #(.NUM_CHANNELS(3), .COUNT_WIDTH(8), .PC_WIDTH(8), .FINAL_PC(100),
                   .NUMBER_OF_DIGITS(2)) dut1 (.CLK_50(clk), .resetN(rst_r[1]), .mon(if1));

    assign if0.cpu_tick = tick_r[0];
    assign if0.pc       = pc_r[0];
    assign if0.events   = ev_r[0];
    assign if0.sel      = sel_r[0];
    assign if0.clear    = clr_r[0];
    assign if1.cpu_tick = tick_r[1];
    assign if1.pc       = pc_r[1][7:0];
    assign if1.events   = ev_r[1][2:0];
    assign if1.sel      = sel_r[1];
    assign if1.clear    = clr_r[1];

    logic [63:0] o_cnt [2], o_sat [2], o_halt [2], o_bcd [2], o_valid [2], o_ovf [2];
    assign o_cnt[0]   = 64'(if0.count_out);
    assign o_sat[0]   = 64'(if0.saturated);
    assign o_halt[0]  = 64'(if0.halted);
    assign o_bcd[0]   = 64'(if0.bcd_digits);
    assign o_valid[0] = 64'(if0.bcd_valid);
    assign o_ovf[0]   = 64'(if0.dec_ovf);
    assign o_cnt[1]   = 64'(if1.count_out);
    assign o_sat[1]   = 64'(if1.saturated);
    assign o_halt[1]  = 64'(if1.halted);
    assign o_bcd[1]   = 64'(if1.bcd_digits);
    assign o_valid[1] = 64'(if1.bcd_valid);
    assign o_ovf[1]   = 64'(if1.dec_ovf);

    int     nch    [2] = '{4, 3};
    int     cw     [2] = '{32, 8};
    int     nd     [2] = '{8, 2};
    longint fin_pc [2] = '{4095, 100};

    longint   m_cnt   [2][4];
    bit [3:0] m_sat   [2];
    bit       m_halt  [2];
    longint   m_snap  [2];
    longint   m_bcd   [2];
    bit       m_valid [2];
    bit       m_ovf   [2];
    int       k       [2];

    int checks = 0;
    int errors = 0;

    function automatic longint pow10(int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic longint to_bcd(longint v, int n);
        longint r = 0;
        longint x = v;
        for (int j = 0; j < n; j++) begin
            r = r | ((x % 10) << (4 * j));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Conversion is periodic from reset release: snapshot on phase 0, result on the last phase
    task automatic model_edge(int u);
        longint maxv = (longint'(1) << cw[u]) - 1;
        int     p    = cw[u] + 2;
        if (!rst_r[u]) begin
            for (int i = 0; i < 4; i++) m_cnt[u][i] = 0;
            m_sat[u] = '0; m_halt[u] = 0; m_snap[u] = 0;
            m_bcd[u] = 0; m_valid[u] = 0; m_ovf[u] = 0; k[u] = 0;
        end else begin
            if (k[u] % p == 0)
                m_snap[u] = (int'(sel_r[u]) < nch[u]) ? m_cnt[u][sel_r[u]] : 0;
            if (k[u] % p == p - 1) begin
                if (m_snap[u] >= pow10(nd[u])) begin
                    m_bcd[u] = to_bcd(pow10(nd[u]) - 1, nd[u]);
                    m_ovf[u] = 1;
                end else begin
                    m_bcd[u] = to_bcd(m_snap[u], nd[u]);
                    m_ovf[u] = 0;
                end
                m_valid[u] = 1;
            end
            k[u]++;
            if (clr_r[u]) begin
                for (int i = 0; i < 4; i++) m_cnt[u][i] = 0;
                m_sat[u] = '0;
                m_halt[u] = 0;
            end else if (!m_halt[u] && tick_r[u]) begin
                for (int i = 0; i < nch[u]; i++) begin
                    if (ev_r[u][i]) begin
                        if (m_cnt[u][i] == maxv) m_sat[u][i] = 1;
                        else                     m_cnt[u][i] = m_cnt[u][i] + 1;
                    end
                end
                if (longint'(pc_r[u]) == fin_pc[u]) m_halt[u] = 1;
            end
        end
    endtask

    task automatic check_outputs(int u);
        longint ce = (int'(sel_r[u]) < nch[u]) ? m_cnt[u][sel_r[u]] : 0;
        chk($sformatf("u%0d_count_out", u), o_cnt[u], 64'(ce));
        chk($sformatf("u%0d_saturated", u), o_sat[u], 64'(m_sat[u]));
        chk($sformatf("u%0d_halted", u), o_halt[u], 64'(m_halt[u]));
        chk($sformatf("u%0d_bcd_digits", u), o_bcd[u], 64'(m_bcd[u]));
        chk($sformatf("u%0d_bcd_valid", u), o_valid[u], 64'(m_valid[u]));
        chk($sformatf("u%0d_dec_ovf", u), o_ovf[u], 64'(m_ovf[u]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_outputs(0);
        check_outputs(1);
    endtask

    task automatic run_until_phase(int u, int ph);
        int p = cw[u] + 2;
        for (int n = 0; n < p && (k[u] % p) != ph; n++) step();
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_r[u] = 1'b0; tick_r[u] = 1'b0; pc_r[u] = '0;
            ev_r[u] = '0; sel_r[u] = '0; clr_r[u] = 1'b0;
        end
        step();
        step();
        chk("reset_count", o_cnt[0], 64'd0);
        chk("reset_halted", o_halt[0], 64'd0);
        chk("reset_bcd", o_bcd[0], 64'd0);
        chk("reset_valid", o_valid[0], 64'd0);
        rst_r[0] = 1'b1;
        rst_r[1] = 1'b1;

        // ten qualified events on channel 0
        ev_r[0] = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick_r[0] = 1'b1; step(); tick_r[0] = 1'b0; step();
        end
        for (int i = 0; i < 68; i++) step();
        chk("t1_count", o_cnt[0], 64'd10);
        chk("t1_bcd", o_bcd[0], 64'h00000010);
        chk("t1_valid", o_valid[0], 64'd1);

        // halt on FINAL_PC, that tick still counted
        pc_r[0] = 12'd4095; ev_r[0] = 4'b0011; tick_r[0] = 1'b1;
        step();
        tick_r[0] = 1'b0; pc_r[0] = '0;
        chk("t2_halted", o_halt[0], 64'd1);
        chk("t2_ch0", o_cnt[0], 64'd11);
        ev_r[0] = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick_r[0] = 1'b1; step();
        end
        tick_r[0] = 1'b0;
        sel_r[0] = 2'd1; #1;
        chk("t2_ch1_frozen", o_cnt[0], 64'd1);
        clr_r[0] = 1'b1; step(); clr_r[0] = 1'b0; step();
        chk("t2_clr_halted", o_halt[0], 64'd0);
        chk("t2_clr_count", o_cnt[0], 64'd0);

        // clear wins over a same-cycle halt
        clr_r[0] = 1'b1; tick_r[0] = 1'b1; pc_r[0] = 12'd4095;
        step();
        clr_r[0] = 1'b0; tick_r[0] = 1'b0; pc_r[0] = '0;
        step();
        chk("t5_halted", o_halt[0], 64'd0);
        chk("t5_count", o_cnt[0], 64'd0);

        // saturation and decimal overflow on the narrow instance
        sel_r[1] = 2'd1; ev_r[1] = 4'b0010; tick_r[1] = 1'b1;
        for (int i = 0; i < 258; i++) step();
        tick_r[1] = 1'b0;
        chk("t3_count", o_cnt[1], 64'hFF);
        chk("t3_sat", o_sat[1], 64'b010);
        for (int i = 0; i < 20; i++) step();
        chk("t3_bcd", o_bcd[1], 64'h99);
        chk("t3_ovf", o_ovf[1], 64'd1);
        sel_r[1] = 2'd3; #1;
        chk("sel_oor", o_cnt[1], 64'd0);

        // random traffic on both instances
        for (int n = 0; n < 400; n++) begin
            for (int u = 0; u < 2; u++) begin
                tick_r[u] = 1'($urandom_range(0, 1));
                ev_r[u]   = 4'($urandom_range(0, 15));
                sel_r[u]  = 2'($urandom_range(0, 3));
                clr_r[u]  = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 15) == 0) pc_r[u] = 12'(fin_pc[u]);
                else pc_r[u] = 12'($urandom_range(0, (u == 0) ? 4095 : 255));
            end
            step();
        end
        for (int u = 0; u < 2; u++) begin
            tick_r[u] = 1'b0; clr_r[u] = 1'b0; pc_r[u] = '0; ev_r[u] = '0;
        end

        // sel changes mid-SHIFT: old snapshot finishes first
        clr_r[0] = 1'b1; step(); clr_r[0] = 1'b0;
        tick_r[0] = 1'b1;
        for (int i = 0; i < 5678; i++) begin
            ev_r[0] = (i < 1234) ? 4'b0101 : 4'b0100;
            step();
        end
        tick_r[0] = 1'b0; ev_r[0] = '0; sel_r[0] = 2'd0;
        run_until_phase(0, 0);
        step();
        run_until_phase(0, 10);
        sel_r[0] = 2'd2;
        run_until_phase(0, 33);
        step();
        chk("t4_first", o_bcd[0], 64'h00001234);
        run_until_phase(0, 33);
        step();
        chk("t4_second", o_bcd[0], 64'h00005678);

        // reset pulse during SHIFT
        run_until_phase(0, 15);
        chk("t6_pre_valid", o_valid[0], 64'd1);
        rst_r[0] = 1'b0; step(); rst_r[0] = 1'b1;
        chk("t6_valid", o_valid[0], 64'd0);
        chk("t6_bcd", o_bcd[0], 64'd0);
        chk("t6_count", o_cnt[0], 64'd0);
        chk("t6_halted", o_halt[0], 64'd0);
        for (int i = 0; i < 70; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
